// File: rtl/aes_pkg.sv
// Shared AES datapath definitions.
// Holds the block width, the AES-128 round-key count and the common
// block / round-key-index types used across the AES pipeline stages.
package aes_pkg;

    localparam int unsigned AES_BLOCK_W = 128;
    localparam int unsigned AES_NUM_RK  = 11;

    typedef logic [AES_BLOCK_W-1:0] aes_block_t;
    typedef logic [3:0]             aes_rk_idx_t;

endpackage

// File: rtl/aes_addkey_pipe_if.sv
// Bus bundle for aes_addkey_pipe.
// Groups the round-key write port, the input valid/ready beat, the output
// valid/ready beat and the status outputs (blk_count, err_kidx).
//   master : the surrounding logic (drives key writes, input beats, out_ready)
//   slave  : the AddRoundKey stage itself
interface aes_addkey_pipe_if
    import aes_pkg::*;
#(
    parameter int unsigned NUM_LANES = 1,
    parameter int unsigned KIDX_W    = 4,
    parameter int unsigned CNT_W     = 32
);

    logic                               key_wr_en;
    logic [KIDX_W-1:0]                  key_wr_idx;
    aes_block_t                         key_wr_data;

    logic                               in_valid;
    logic                               in_ready;
    logic [AES_BLOCK_W*NUM_LANES-1:0]   in_data;
    logic [KIDX_W-1:0]                  in_kidx;

    logic                               out_valid;
    logic                               out_ready;
    logic [AES_BLOCK_W*NUM_LANES-1:0]   out_data;
    logic [KIDX_W-1:0]                  out_kidx;

    logic [CNT_W-1:0]                   blk_count;
    logic                               err_kidx;

    modport master (
        output key_wr_en, key_wr_idx, key_wr_data,
        output in_valid, in_data, in_kidx, out_ready,
        input  in_ready, out_valid, out_data, out_kidx, blk_count, err_kidx
    );

    modport slave (
        input  key_wr_en, key_wr_idx, key_wr_data,
        input  in_valid, in_data, in_kidx, out_ready,
        output in_ready, out_valid, out_data, out_kidx, blk_count, err_kidx
    );

endinterface

// File: rtl/aes_skid_buf.sv
// Generic 2-entry valid/ready skid buffer.
// A main (output) register plus one skid register. in_ready_o comes straight
// from a flop, so there is no combinational path from out_ready_i to
// in_ready_o, yet a full 1 beat/cycle stream passes while out_ready_i=1.
//   clk, reset   : clock, synchronous active-high reset (empties both entries)
//   in_*_i/o     : upstream valid/ready/payload
//   out_*_i/o    : downstream valid/ready/payload
module aes_skid_buf #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         main_vld_q, main_vld_d;
    logic         skid_vld_q, skid_vld_d;
    logic         ready_q;
    logic         push, pop;

    assign push = in_valid_i && ready_q;
    assign pop  = main_vld_q && out_ready_i;

    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (pop) begin
            if (skid_vld_q) begin
                // Older skid beat advances; a new beat (if any) refills skid.
                main_d = skid_q;
                if (push) begin
                    skid_d = in_data_i;
                end else begin
                    skid_vld_d = 1'b0;
                end
            end else if (push) begin
                main_d = in_data_i;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (push) begin
            if (!main_vld_q) begin
                main_d     = in_data_i;
                main_vld_d = 1'b1;
            end else begin
                skid_d     = in_data_i;
                skid_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            ready_q    <= !skid_vld_d;
        end
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = main_vld_q;
    assign out_data_o  = main_q;

endmodule

// File: rtl/aes_addkey_pipe.sv
// AES AddRoundKey pipeline stage.
// XORs NUM_LANES 128-bit state blocks with one round key read from an
// internal NUM_KEYS-entry table, registered through a 2-entry skid buffer.
// Also counts completed output handshakes and flags out-of-range key indices.
//   clk, reset : clock, synchronous active-high reset (clears table, counter,
//                error flag and any held beats)
//   bus        : key write port, in/out valid/ready beats, blk_count, err_kidx
module aes_addkey_pipe
    import aes_pkg::*;
#(
    parameter int unsigned NUM_LANES = 1,
    parameter int unsigned NUM_KEYS  = AES_NUM_RK,
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned KIDX_W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    aes_addkey_pipe_if.slave  bus
);

    localparam int unsigned DATA_W = AES_BLOCK_W * NUM_LANES;
    localparam int unsigned PAY_W  = DATA_W + KIDX_W;

    aes_block_t         key_q [NUM_KEYS];
    aes_block_t         key_sel;
    logic               kidx_ok;
    logic [DATA_W-1:0]  xor_data;
    logic [PAY_W-1:0]   pay_out;
    logic               accept;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    // Indices >= NUM_KEYS match no entry, so such writes are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < NUM_KEYS; k++) begin
                key_q[k] <= '0;
            end
        end else if (bus.key_wr_en) begin
            for (int unsigned k = 0; k < NUM_KEYS; k++) begin
                if (bus.key_wr_idx == KIDX_W'(k)) begin
                    key_q[k] <= bus.key_wr_data;
                end
            end
        end
    end

    // Read happens before the edge, so a same-cycle write is not yet visible
    // to the accepted beat. An out-of-range index selects a zero key.
    always_comb begin
        key_sel = '0;
        kidx_ok = 1'b0;
        for (int unsigned k = 0; k < NUM_KEYS; k++) begin
            if (bus.in_kidx == KIDX_W'(k)) begin
                key_sel = key_q[k];
                kidx_ok = 1'b1;
            end
        end
    end

    always_comb begin
        xor_data = '0;
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
            xor_data[l*AES_BLOCK_W +: AES_BLOCK_W] =
                bus.in_data[l*AES_BLOCK_W +: AES_BLOCK_W] ^ key_sel;
        end
    end

    aes_skid_buf #(
        .W (PAY_W)
    ) u_skid (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (bus.in_valid),
        .in_ready_o  (bus.in_ready),
        .in_data_i   ({xor_data, bus.in_kidx}),
        .out_valid_o (bus.out_valid),
        .out_ready_i (bus.out_ready),
        .out_data_o  (pay_out)
    );

    assign bus.out_data = pay_out[PAY_W-1:KIDX_W];
    assign bus.out_kidx = pay_out[KIDX_W-1:0];

    assign accept = bus.in_valid && bus.in_ready;

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (bus.out_valid && bus.out_ready) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (accept && !kidx_ok) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign bus.blk_count = cnt_q;
    assign bus.err_kidx  = err_q;

endmodule

// File: tb/tb_aes_addkey_pipe.sv
// Self-checking bench for aes_addkey_pipe (2 lanes, 4-bit counter).
// A negedge monitor keeps a reference key table, pushes the expected result
// of every accepted beat to a queue and pops it on every output handshake.
module tb_aes_addkey_pipe;
    import aes_pkg::*;

    localparam int unsigned NL = 2;
    localparam int unsigned NK = 11;
    localparam int unsigned CW = 4;
    localparam int unsigned KW = 4;
    localparam int unsigned DW = 128 * NL;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    aes_addkey_pipe_if #(.NUM_LANES(NL), .KIDX_W(KW), .CNT_W(CW)) bus ();

    aes_addkey_pipe #(
        .NUM_LANES (NL),
        .NUM_KEYS  (NK),
        .CNT_W     (CW),
        .KIDX_W    (KW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] kidx;
    } beat_t;

    beat_t            exp_q[$];
    logic [127:0]     mkey [16];
    int unsigned      cnt_m;
    bit               err_m;
    bit               stalled;
    logic [DW+KW-1:0] held;
    int               checks = 0;
    int               errors = 0;

    task automatic check(input string tag, input logic [263:0] act, input logic [263:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // Reference model and scoreboard.
    always @(negedge clk) begin
        beat_t        b;
        logic [127:0] k;
        if (reset) begin
            exp_q.delete();
            for (int i = 0; i < 16; i++) mkey[i] = '0;
            cnt_m   = 0;
            err_m   = 1'b0;
            stalled = 1'b0;
        end else begin
            check("blk_count", bus.blk_count, cnt_m[CW-1:0]);
            check("err_kidx", bus.err_kidx, err_m);
            if (stalled) check("stall_hold", {bus.out_data, bus.out_kidx}, held);
            stalled = bus.out_valid && !bus.out_ready;
            held    = {bus.out_data, bus.out_kidx};
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", bus.out_valid, 1'b0);
                end else begin
                    b = exp_q.pop_front();
                    check("out_data", bus.out_data, b.data);
                    check("out_kidx", bus.out_kidx, b.kidx);
                end
                cnt_m = (cnt_m + 1) % 16;
            end
            if (bus.in_valid && bus.in_ready) begin
                k = '0;
                if (bus.in_kidx < NK) k = mkey[bus.in_kidx];
                b.data = {bus.in_data[255:128] ^ k, bus.in_data[127:0] ^ k};
                b.kidx = bus.in_kidx;
                exp_q.push_back(b);
                if (bus.in_kidx >= NK) err_m = 1'b1;
            end
            if (bus.key_wr_en && bus.key_wr_idx < NK) mkey[bus.key_wr_idx] = bus.key_wr_data;
        end
    end

    task automatic send(input logic [255:0] d, input logic [3:0] k);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_kidx  = k;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) check("send_timeout", bus.in_ready, 1'b1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic write_key(input logic [3:0] idx, input logic [127:0] d);
        bus.key_wr_en   = 1'b1;
        bus.key_wr_idx  = idx;
        bus.key_wr_data = d;
        @(posedge clk);
        #1 bus.key_wr_en = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [255:0] exp);
        int n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (n >= 20) check({tag, "_timeout"}, bus.out_valid, 1'b1);
        else check(tag, bus.out_data, exp);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.key_wr_en   = 1'b0;
        bus.key_wr_idx  = '0;
        bus.key_wr_data = '0;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.in_kidx     = '0;
        bus.out_ready   = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_data", {bus.out_data, bus.out_kidx}, '0);
        check("rst_blk_count", bus.blk_count, '0);
        check("rst_err_kidx", bus.err_kidx, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("in_ready_after_rst", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;

        // FIPS-197 AddRoundKey vector on both lanes
        write_key(4'd0, 128'h000102030405060708090a0b0c0d0e0f);
        send({2{128'h00112233445566778899aabbccddeeff}}, 4'd0);
        expect_out("t1_fips", {2{128'h00102030405060708090a0b0c0d0e0f0}});
        @(negedge clk);
        check("t1_blk_count", bus.blk_count, 4'd1);
        @(posedge clk);
        #1;

        // Backpressure: A, B fill main+skid, C waits
        bus.out_ready = 1'b0;
        send(rnd256(), 4'd1);
        send(rnd256(), 4'd2);
        @(negedge clk);
        check("t2_in_ready_full", bus.in_ready, 1'b0);
        fork
            send(rnd256(), 4'd3);
            begin
                repeat (4) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;

        // Same-cycle key write and accept uses the old key
        bus.key_wr_en   = 1'b1;
        bus.key_wr_idx  = 4'd3;
        bus.key_wr_data = '1;
        send('0, 4'd3);
        bus.key_wr_en = 1'b0;
        expect_out("t3_old_key", '0);
        send('0, 4'd3);
        expect_out("t3_new_key", '1);
        repeat (2) @(posedge clk);
        #1;

        // Out-of-range index passes data through and sets the sticky flag
        send({128'hdeadbeef_01234567_89abcdef_deadbeef, 128'hcafebabe_76543210_fedcba98_cafebabe}, 4'd11);
        expect_out("t4_passthru", {128'hdeadbeef_01234567_89abcdef_deadbeef, 128'hcafebabe_76543210_fedcba98_cafebabe});
        @(negedge clk);
        check("t4_err_set", bus.err_kidx, 1'b1);
        @(posedge clk);
        #1;
        for (int k = 0; k < 11; k++) write_key(4'(k), rnd256()[127:0]);
        write_key(4'd12, 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321);
        for (int k = 0; k < 11; k++) send(rnd256(), 4'(k));
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("t4_err_sticky", bus.err_kidx, 1'b1);
        @(posedge clk);
        #1;

        // Reset mid-stream with two held beats
        bus.out_ready = 1'b0;
        send(rnd256(), 4'd4);
        send(rnd256(), 4'd5);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("t5_out_valid", bus.out_valid, 1'b0);
        check("t5_blk_count", bus.blk_count, '0);
        check("t5_err_kidx", bus.err_kidx, 1'b0);
        check("t5_in_ready_rst", bus.in_ready, 1'b0);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t5_in_ready_post", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        send({2{128'h55555555555555555555555555555555}}, 4'd0);
        expect_out("t5_zero_key", {2{128'h55555555555555555555555555555555}});

        // Counter wrap over 17 back-to-back handshakes
        do_reset();
        for (int k = 0; k < 11; k++) write_key(4'(k), rnd256()[127:0]);
        for (int i = 0; i < 17; i++) send(rnd256(), 4'($urandom_range(0, 10)));
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("t6_wrap", bus.blk_count, 4'd1);
        @(posedge clk);
        #1;

        // Random backpressure stream
        fork
            for (int i = 0; i < 24; i++) send(rnd256(), 4'($urandom_range(0, 10)));
            for (int i = 0; i < 40; i++) begin
                @(posedge clk);
                #1 bus.out_ready = 1'($urandom_range(0, 1));
            end
        join
        bus.out_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("sb_drain", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_addkey_pipe.md
Name: aes_addkey_pipe

Overview:
Parametrised AddRoundKey pipeline stage for the AES datapath: XORs one or more 128-bit state blocks with a round key selected from an internal round-key table. It carries a valid/ready handshake with a 2-entry skid buffer, so it can sit between HPS-fed input logic and the round pipeline at full throughput under backpressure. It also keeps a processed-block counter and a sticky key-index error flag.

Parameters:
NUM_LANES, 1, parallel 128-bit blocks per beat; all lanes share one key.
NUM_KEYS, 11, round-key table depth (AES-128: rk0..rk10).
CNT_W, 32, width of the processed-beat counter.
KIDX_W, 4, round-key index width; must satisfy 2**KIDX_W >= NUM_KEYS.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high reset.
key_wr_en  in  1  write strobe for the round-key table.
key_wr_idx  in  KIDX_W  table entry to write.
key_wr_data  in  128  round key value.
in_valid  in  1  input beat valid.
in_ready  out  1  stage can accept a beat.
in_data  in  128*NUM_LANES  state blocks; lane i is bits [128*i +: 128].
in_kidx  in  KIDX_W  round-key index for this beat.
out_valid  out  1  output beat valid.
out_ready  in  1  downstream accepts.
out_data  out  128*NUM_LANES  in_data XOR key, per lane.
out_kidx  out  KIDX_W  in_kidx carried with the beat.
blk_count  out  CNT_W  count of completed output handshakes.
err_kidx  out  1  sticky: a beat arrived with in_kidx >= NUM_KEYS.

Behaviour:
- Reset, when reset=1 at a clk edge:
  - out_valid=0, out_data=0, out_kidx=0, blk_count=0, err_kidx=0.
  - Skid buffer emptied; all key table entries cleared to 0.
  - in_ready=0 while reset is asserted.
  - Reset mid-stream drops any held beats; nothing is replayed.
- Accept: in_valid && in_ready at a clk edge.
  - The key is read from the table at accept time.
  - The XOR result is registered. Latency is 1 cycle: out_valid rises the edge after accept.
- Storage: main output register plus one skid register.
  - On accept, the beat goes to main if main is empty or is being consumed this cycle (out_valid && out_ready); otherwise it goes to skid.
  - When main is consumed and skid is full, skid moves to main on the same edge. Any simultaneous new accept then goes to skid.
  - in_ready = !skid_full, driven from a register (no combinational path from out_ready to in_ready).
  - Beat order is always preserved.
  - Sustained throughput is 1 beat/cycle while out_ready=1.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_kidx hold constant.
- Key table:
  - key_wr_en writes entry key_wr_idx at the edge.
  - A write to an index >= NUM_KEYS is ignored.
  - Same-cycle write and accept on the same index: the accepted beat uses the OLD key; the new key applies from the next accept.
  - Writes are allowed at any time, independent of the handshake.
- Out-of-range in_kidx (>= NUM_KEYS):
  - The beat is still accepted and passed through with key = 0 (out_data = in_data).
  - err_kidx is set and stays 1 until reset.
- Counter: blk_count increments by 1 on every out_valid && out_ready edge and wraps modulo 2**CNT_W.
- Lanes: all NUM_LANES lanes use the same selected key; there is no per-lane key.

Decomposition:
- Shared package aes_pkg holds:
  - AES_BLOCK_W=128, AES_NUM_RK=11.
  - typedef logic [127:0] aes_block_t.
  - typedef logic [3:0] aes_rk_idx_t.
- One sub-module, aes_skid_buf: a generic 2-entry valid/ready skid buffer, parametrised by payload width.
  - aes_addkey_pipe owns the key table, the XOR, the counter and the error flag.
  - It instantiates aes_skid_buf with payload {xor result, kidx}.

Test Plan:
1. FIPS-197 vector: write rk0=000102030405060708090a0b0c0d0e0f; send in_data=00112233445566778899aabbccddeeff, kidx=0, out_ready=1 -> one cycle later out_data=00102030405060708090a0b0c0d0e0f0, out_kidx=0, blk_count=1.
2. Backpressure: out_ready=0, in_valid=1 with beats A, B, C -> A and B accepted, in_ready=0 on the cycle after B. Raise out_ready -> A, B, C emitted in order, no loss or duplication, out_data stable while stalled.
3. Key hazard: rk3=0 holds; in the same cycle write rk3=FF..FF and accept a beat with kidx=3, data=0 -> output is 0. The next beat with kidx=3, data=0 -> output is FF..FF.
4. Out-of-range: NUM_KEYS=11, send kidx=11, data=DEADBEEF... -> out_data equals in_data, err_kidx=1 and stays 1 through later good beats. A key write to idx 12 leaves the table unchanged.
5. Reset mid-stream: two beats held under out_ready=0, pulse reset -> out_valid=0, blk_count=0, err_kidx=0, in_ready=0 during reset then 1. Table reads back zero: data 55.. with kidx=0 -> out_data 55...
6. Multi-lane and wrap: NUM_LANES=2, CNT_W=4; stream 17 beats with each lane's data XOR key checked -> both lanes correct, blk_count reads 1 after the 17th handshake.
